// File: rtl/uop_mem_access_pkg.sv
// Shared definitions for the memory access stage: FSM states, command/width codes
// and the captured request descriptor.
package uop_mem_access_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } mem_state_e;

  localparam logic MEM_CMD_RD = 1'b0;
  localparam logic MEM_CMD_WR = 1'b1;

  localparam logic MEM_W_BYTE = 1'b0;
  localparam logic MEM_W_WORD = 1'b1;

  // Request attributes held for the whole access; write high byte waits for the HI phase.
  typedef struct packed {
    logic       cmd;
    logic       width;
    logic [7:0] wdata_hi;
  } mem_req_t;

endpackage

// File: rtl/mem_addr_inc.sv
// Combinational next-byte address; PAGE_WRAP=1 keeps the upper byte (256-byte page wrap),
// PAGE_WRAP=0 does a full 16-bit increment wrapping 0xFFFF to 0x0000.
module mem_addr_inc #(
  parameter int unsigned PAGE_WRAP = 0
) (
  input  logic [15:0] addr_i,
  output logic [15:0] addr_o
);

  logic [7:0]  lo_inc;
  logic [15:0] full_inc;

  assign lo_inc   = addr_i[7:0] + 8'd1;
  assign full_inc = addr_i + 16'd1;
  assign addr_o   = (PAGE_WRAP != 0) ? {addr_i[15:8], lo_inc} : full_inc;

endmodule

// File: rtl/uop_mem_access.sv
// Memory access stage: byte/word accesses over an 8-bit req/ack bus, min 2 cycles (byte) / 3 (word).
// Stalls execute via registered stop while busy; requests or MAR writes arriving while busy are dropped.
module uop_mem_access #(
  parameter int unsigned PAGE_WRAP = 0
) (
  input  logic        clk,
  input  logic        a_rst,
  input  logic        mar_wr,
  input  logic [15:0] mar_in,
  input  logic        mem_rq,
  input  logic        mem_rq_cmd,
  input  logic        mem_rq_width,
  input  logic        mem_tag,
  input  logic [15:0] wr_data,
  output logic        stop,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        rd_tag,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        bus_we,
  output logic        bus_req,
  input  logic        bus_ack,
  input  logic [7:0]  bus_rdata
);

  import uop_mem_access_pkg::*;

  mem_state_e  state_q, state_d;
  mem_req_t    req_q, req_d;
  logic [15:0] mar_q, mar_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        rd_tag_q, rd_tag_d;
  logic [15:0] bus_addr_q, bus_addr_d;
  logic [7:0]  bus_wdata_q, bus_wdata_d;
  logic        bus_we_q, bus_we_d;
  logic        bus_req_q, bus_req_d;

  logic [15:0] eff_addr;
  logic [15:0] next_addr;
  logic        xfer_done;

  mem_addr_inc #(
    .PAGE_WRAP(PAGE_WRAP)
  ) u_addr_inc (
    .addr_i(bus_addr_q),
    .addr_o(next_addr)
  );

  // Same-cycle MAR write bypasses into the access address.
  assign eff_addr  = mar_wr ? mar_in : mar_q;
  assign xfer_done = bus_ack && bus_req_q;

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    mar_d       = mar_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    rd_tag_d    = rd_tag_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_we_d    = bus_we_q;
    bus_req_d   = bus_req_q;

    case (state_q)
      IDLE: begin
        if (mar_wr) begin
          mar_d = mar_in;
        end
        if (mem_rq) begin
          req_d.cmd      = mem_rq_cmd;
          req_d.width    = mem_rq_width;
          req_d.wdata_hi = wr_data[15:8];
          rd_tag_d       = mem_tag;
          bus_addr_d     = eff_addr;
          bus_we_d       = mem_rq_cmd;
          bus_wdata_d    = wr_data[7:0];
          bus_req_d      = 1'b1;
          state_d        = LO;
        end
      end

      LO: begin
        if (xfer_done) begin
          if (req_q.cmd == MEM_CMD_RD) begin
            rd_data_d[7:0] = bus_rdata;
            if (req_q.width == MEM_W_BYTE) begin
              rd_data_d[15:8] = 8'h00;
            end
          end
          if (req_q.width == MEM_W_WORD) begin
            bus_addr_d  = next_addr;
            bus_wdata_d = req_q.wdata_hi;
            state_d     = HI;
          end else begin
            bus_req_d  = 1'b0;
            bus_we_d   = 1'b0;
            rd_valid_d = (req_q.cmd == MEM_CMD_RD);
            state_d    = DONE;
          end
        end
      end

      HI: begin
        if (xfer_done) begin
          if (req_q.cmd == MEM_CMD_RD) begin
            rd_data_d[15:8] = bus_rdata;
          end
          bus_req_d  = 1'b0;
          bus_we_d   = 1'b0;
          rd_valid_d = (req_q.cmd == MEM_CMD_RD);
          state_d    = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      state_q     <= IDLE;
      req_q       <= '0;
      mar_q       <= 16'h0000;
      rd_data_q   <= 16'h0000;
      rd_valid_q  <= 1'b0;
      rd_tag_q    <= 1'b0;
      bus_addr_q  <= 16'h0000;
      bus_wdata_q <= 8'h00;
      bus_we_q    <= 1'b0;
      bus_req_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      mar_q       <= mar_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      rd_tag_q    <= rd_tag_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_we_q    <= bus_we_d;
      bus_req_q   <= bus_req_d;
    end
  end

  // Decoded straight from the state register so stop never depends on mem_rq.
  assign stop      = (state_q != IDLE);
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign rd_tag    = rd_tag_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_we    = bus_we_q;
  assign bus_req   = bus_req_q;

endmodule

// File: tb/tb_uop_mem_access.sv
// Directed bench for uop_mem_access: one instance per PAGE_WRAP setting, shared stimulus.
module tb_uop_mem_access;

  logic        clk;
  logic        a_rst;
  logic        mar_wr;
  logic [15:0] mar_in;
  logic        mem_rq;
  logic        mem_rq_cmd;
  logic        mem_rq_width;
  logic        mem_tag;
  logic [15:0] wr_data;
  logic        bus_ack;
  logic [7:0]  bus_rdata;

  logic        stop0, rd_valid0, rd_tag0, bus_we0, bus_req0;
  logic [15:0] rd_data0, bus_addr0;
  logic [7:0]  bus_wdata0;
  logic        stop1, rd_valid1, rd_tag1, bus_we1, bus_req1;
  logic [15:0] rd_data1, bus_addr1;
  logic [7:0]  bus_wdata1;

  int checks = 0;
  int errors = 0;

  uop_mem_access #(.PAGE_WRAP(0)) dut0 (
    .clk(clk), .a_rst(a_rst), .mar_wr(mar_wr), .mar_in(mar_in),
    .mem_rq(mem_rq), .mem_rq_cmd(mem_rq_cmd), .mem_rq_width(mem_rq_width),
    .mem_tag(mem_tag), .wr_data(wr_data), .stop(stop0), .rd_data(rd_data0),
    .rd_valid(rd_valid0), .rd_tag(rd_tag0), .bus_addr(bus_addr0),
    .bus_wdata(bus_wdata0), .bus_we(bus_we0), .bus_req(bus_req0),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  uop_mem_access #(.PAGE_WRAP(1)) dut1 (
    .clk(clk), .a_rst(a_rst), .mar_wr(mar_wr), .mar_in(mar_in),
    .mem_rq(mem_rq), .mem_rq_cmd(mem_rq_cmd), .mem_rq_width(mem_rq_width),
    .mem_tag(mem_tag), .wr_data(wr_data), .stop(stop1), .rd_data(rd_data1),
    .rd_valid(rd_valid1), .rd_tag(rd_tag1), .bus_addr(bus_addr1),
    .bus_wdata(bus_wdata1), .bus_we(bus_we1), .bus_req(bus_req1),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_rst = 1'b0; mar_wr = 1'b0; mar_in = 16'h0; mem_rq = 1'b0; mem_rq_cmd = 1'b0;
    mem_rq_width = 1'b0; mem_tag = 1'b0; wr_data = 16'h0; bus_ack = 1'b0; bus_rdata = 8'h0;
    #2;
    checks++;
    if ({stop0, rd_valid0, rd_tag0, bus_we0, bus_req0, rd_data0, bus_addr0, bus_wdata0} !== 45'd0) begin
      errors++;
      $display("FAIL reset_dut0: got stop=%b vld=%b tag=%b we=%b req=%b rd=%h addr=%h wd=%h exp all 0",
               stop0, rd_valid0, rd_tag0, bus_we0, bus_req0, rd_data0, bus_addr0, bus_wdata0);
    end
    checks++;
    if ({stop1, rd_valid1, rd_tag1, bus_we1, bus_req1, rd_data1, bus_addr1, bus_wdata1} !== 45'd0) begin
      errors++;
      $display("FAIL reset_dut1: got stop=%b vld=%b tag=%b we=%b req=%b rd=%h addr=%h wd=%h exp all 0",
               stop1, rd_valid1, rd_tag1, bus_we1, bus_req1, rd_data1, bus_addr1, bus_wdata1);
    end
    tick();
    tick();
    #2 a_rst = 1'b1;
  endtask

  task automatic test_byte_read();
    int stop_cnt = 0;
    int vld_cnt  = 0;
    mar_wr = 1'b1; mar_in = 16'h1234;
    tick();
    mar_wr = 1'b0; mar_in = 16'h0;
    tick();
    mem_rq = 1'b1; mem_rq_cmd = 1'b0; mem_rq_width = 1'b0; mem_tag = 1'b0;
    tick();
    mem_rq = 1'b0;
    checks++;
    if (bus_addr0 !== 16'h1234 || bus_req0 !== 1'b1 || bus_we0 !== 1'b0) begin
      errors++;
      $display("FAIL byte_read_bus: got addr=%h req=%b we=%b exp 1234/1/0", bus_addr0, bus_req0, bus_we0);
    end
    for (int i = 0; i < 6; i++) begin
      if (stop0) stop_cnt++;
      if (rd_valid0) begin
        vld_cnt++;
        checks++;
        if (rd_data0 !== 16'h00AB || rd_tag0 !== 1'b0) begin
          errors++;
          $display("FAIL byte_read_data: got rd=%h tag=%b exp 00ab/0", rd_data0, rd_tag0);
        end
      end
      bus_ack = (i == 0); bus_rdata = (i == 0) ? 8'hAB : 8'h00;
      tick();
    end
    bus_ack = 1'b0;
    checks++;
    if (stop_cnt != 2 || vld_cnt != 1) begin
      errors++;
      $display("FAIL byte_read_counts: got stop=%0d valid=%0d exp 2/1", stop_cnt, vld_cnt);
    end
  endtask

  task automatic test_word_write_wait();
    logic [15:0] xa [2];
    logic [7:0]  xd [2];
    int nx = 0; int wcnt = 0; int stop_cnt = 0; int vld_cnt = 0; int we_bad = 0;
    mar_wr = 1'b1; mar_in = 16'h20FF;
    tick();
    mar_wr = 1'b0;
    mem_rq = 1'b1; mem_rq_cmd = 1'b1; mem_rq_width = 1'b1; wr_data = 16'hBEEF;
    tick();
    mem_rq = 1'b0; wr_data = 16'h0000;
    for (int k = 0; k < 14; k++) begin
      if (stop0) stop_cnt++;
      if (rd_valid0) vld_cnt++;
      if (bus_req0 && !bus_we0) we_bad++;
      bus_ack = 1'b0;
      if (bus_req0) begin
        if (wcnt == 3) begin
          bus_ack = 1'b1;
          if (nx < 2) begin
            xa[nx] = bus_addr0;
            xd[nx] = bus_wdata0;
          end
          nx++;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end
      tick();
    end
    bus_ack = 1'b0;
    checks++;
    if (nx != 2) begin
      errors++;
      $display("FAIL word_write_xfers: got %0d transfers exp 2", nx);
    end else begin
      checks++;
      if (xa[0] !== 16'h20FF || xd[0] !== 8'hEF) begin
        errors++;
        $display("FAIL word_write_lo: got %h/%h exp 20ff/ef", xa[0], xd[0]);
      end
      checks++;
      if (xa[1] !== 16'h2100 || xd[1] !== 8'hBE) begin
        errors++;
        $display("FAIL word_write_hi: got %h/%h exp 2100/be", xa[1], xd[1]);
      end
    end
    checks++;
    if (stop_cnt != 9 || vld_cnt != 0 || we_bad != 0 || stop0 !== 1'b0) begin
      errors++;
      $display("FAIL word_write_ctrl: got stop_cycles=%0d valid=%0d we_low=%0d stop_now=%b exp 9/0/0/0",
               stop_cnt, vld_cnt, we_bad, stop0);
    end
  endtask

  task automatic word_read_wrap(input logic [15:0] base, input logic [15:0] exp_hi0,
                                input logic [15:0] exp_hi1);
    mar_wr = 1'b1; mar_in = base;
    tick();
    mar_wr = 1'b0;
    mem_rq = 1'b1; mem_rq_cmd = 1'b0; mem_rq_width = 1'b1;
    tick();
    mem_rq = 1'b0;
    checks++;
    if (bus_addr0 !== base || bus_addr1 !== base) begin
      errors++;
      $display("FAIL wrap_lo_addr: got %h/%h exp %h", bus_addr0, bus_addr1, base);
    end
    bus_ack = 1'b1; bus_rdata = 8'h34;
    tick();
    checks++;
    if (bus_addr0 !== exp_hi0 || bus_addr1 !== exp_hi1 || bus_req0 !== 1'b1) begin
      errors++;
      $display("FAIL wrap_hi_addr: got wrap0=%h wrap1=%h req=%b exp %h/%h/1", bus_addr0, bus_addr1, bus_req0,
               exp_hi0, exp_hi1);
    end
    bus_ack = 1'b1; bus_rdata = 8'h12;
    tick();
    bus_ack = 1'b0; bus_rdata = 8'h00;
    checks++;
    if (rd_data0 !== 16'h1234 || rd_data1 !== 16'h1234 || rd_valid0 !== 1'b1 || rd_valid1 !== 1'b1) begin
      errors++;
      $display("FAIL wrap_data: got %h/%h valid=%b%b exp 1234 valid=11", rd_data0, rd_data1, rd_valid0, rd_valid1);
    end
    tick();
  endtask

  task automatic test_wrap();
    word_read_wrap(16'h12FF, 16'h1300, 16'h1200);
    word_read_wrap(16'hFFFF, 16'h0000, 16'hFF00);
  endtask

  task automatic test_bypass_tag();
    mar_wr = 1'b1; mar_in = 16'h1000;
    tick();
    mar_in = 16'h4000; mem_rq = 1'b1; mem_tag = 1'b1; mem_rq_cmd = 1'b0; mem_rq_width = 1'b0;
    tick();
    mar_wr = 1'b0; mem_rq = 1'b0; mem_tag = 1'b0;
    checks++;
    if (bus_addr0 !== 16'h4000) begin
      errors++;
      $display("FAIL bypass_addr: got %h exp 4000", bus_addr0);
    end
    bus_ack = 1'b1; bus_rdata = 8'h5A;
    tick();
    bus_ack = 1'b0;
    checks++;
    if (rd_tag0 !== 1'b1 || rd_valid0 !== 1'b1 || rd_data0 !== 16'h005A) begin
      errors++;
      $display("FAIL bypass_tag: got tag=%b valid=%b rd=%h exp 1/1/005a", rd_tag0, rd_valid0, rd_data0);
    end
    tick();
  endtask

  task automatic test_busy_reject();
    int bad = 0;
    mem_rq = 1'b1; mem_rq_cmd = 1'b0; mem_rq_width = 1'b0;
    tick();
    mem_rq = 1'b1; mar_wr = 1'b1; mar_in = 16'h5555;
    tick();
    mem_rq = 1'b0; mar_wr = 1'b0;
    bus_ack = 1'b1; bus_rdata = 8'h11;
    tick();
    bus_ack = 1'b0;
    checks++;
    if (rd_valid0 !== 1'b1 || rd_data0 !== 16'h0011) begin
      errors++;
      $display("FAIL busy_first: got valid=%b rd=%h exp 1/0011", rd_valid0, rd_data0);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      bus_ack = (i >= 2); bus_rdata = 8'hFF;
      if (stop0 || bus_req0 || rd_valid0 || rd_data0 !== 16'h0011) bad++;
      tick();
    end
    bus_ack = 1'b0;
    checks++;
    if (bad != 0 || stop0 || rd_data0 !== 16'h0011) begin
      errors++;
      $display("FAIL busy_idle: got %0d disturbed cycles stop=%b rd=%h exp 0/0/0011", bad, stop0, rd_data0);
    end
    mem_rq = 1'b1;
    tick();
    mem_rq = 1'b0;
    checks++;
    if (bus_addr0 !== 16'h4000) begin
      errors++;
      $display("FAIL busy_mar: got %h exp 4000", bus_addr0);
    end
    bus_ack = 1'b1; bus_rdata = 8'h22;
    tick();
    bus_ack = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    mem_rq = 1'b1; mem_rq_cmd = 1'b0; mem_rq_width = 1'b1;
    tick();
    mem_rq = 1'b0;
    bus_ack = 1'b1; bus_rdata = 8'h77;
    tick();
    bus_ack = 1'b0;
    checks++;
    if (stop0 !== 1'b1 || bus_req0 !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_hi: got stop=%b req=%b exp 1/1", stop0, bus_req0);
    end
    #2 a_rst = 1'b0;
    #1;
    checks++;
    if (bus_req0 !== 1'b0 || stop0 !== 1'b0 || rd_valid0 !== 1'b0 || bus_req1 !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_async: got req=%b stop=%b valid=%b req1=%b exp 0", bus_req0, stop0, rd_valid0, bus_req1);
    end
    @(posedge clk);
    #3 a_rst = 1'b1;
    mar_wr = 1'b1; mar_in = 16'h0042; mem_rq = 1'b1; mem_rq_width = 1'b0;
    tick();
    mar_wr = 1'b0; mem_rq = 1'b0;
    checks++;
    if (bus_addr0 !== 16'h0042 || bus_req0 !== 1'b1) begin
      errors++;
      $display("FAIL rst_after_addr: got %h req=%b exp 0042/1", bus_addr0, bus_req0);
    end
    bus_ack = 1'b1; bus_rdata = 8'h9C;
    tick();
    bus_ack = 1'b0;
    checks++;
    if (rd_valid0 !== 1'b1 || rd_data0 !== 16'h009C) begin
      errors++;
      $display("FAIL rst_after_data: got valid=%b rd=%h exp 1/009c", rd_valid0, rd_data0);
    end
    tick();
    checks++;
    if (stop0 !== 1'b0 || rd_valid0 !== 1'b0) begin
      errors++;
      $display("FAIL rst_after_idle: got stop=%b valid=%b exp 0/0", stop0, rd_valid0);
    end
  endtask

  initial begin
    test_reset();
    test_byte_read();
    test_word_write_wait();
    test_wrap();
    test_bypass_tag();
    test_busy_reject();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uop_mem_access.md
Name: uop_mem_access

Overview:
- Memory access stage directly downstream of the uop execute stage.
- Consumes the execute stage's MAR write, memory request, command and width strobes, and the context tag.
- Runs 8-bit or 16-bit accesses over the 8-bit external bus using a req/ack handshake, with 16-bit words done as two byte transfers.
- Returns read data tagged with the issuing context, and drives the registered `stop` stall back to the execute stage.

Parameters:
- PAGE_WRAP, 0: 1 = the high byte of a word stays in the same 256-byte page (addr[7:0]+1, addr[15:8] kept); 0 = full 16-bit increment, 0xFFFF wraps to 0x0000.

Ports:
- clk  in  1  clock, rising edge
- a_rst  in  1  reset, asynchronous, active-low
- mar_wr  in  1  load MAR from mar_in
- mar_in  in  16  address from ALU result
- mem_rq  in  1  access request, one-cycle strobe
- mem_rq_cmd  in  1  1 = write, 0 = read
- mem_rq_width  in  1  1 = 16-bit word, 0 = byte
- mem_tag  in  1  issuing context (main/sched), returned with result
- wr_data  in  16  write data; low byte first
- stop  out  1  stall to execute stage; registered
- rd_data  out  16  read result; byte reads zero-extended
- rd_valid  out  1  one-cycle pulse, rd_data/rd_tag valid
- rd_tag  out  1  mem_tag captured at request
- bus_addr  out  16  external address, registered
- bus_wdata  out  8  external write byte, registered
- bus_we  out  1  external write enable, registered
- bus_req  out  1  external request, registered
- bus_ack  in  1  external transfer complete
- bus_rdata  in  8  external read byte, sampled on ack

Behaviour:
- Reset (async, immediate): state IDLE. MAR, stop, rd_data, rd_valid, rd_tag, bus_addr, bus_wdata, bus_we, bus_req all 0. A reset mid-access aborts the access; bus_req drops without waiting for ack.
- States: IDLE, LO, HI, DONE.
- `stop` = (state != IDLE). It is taken directly from the state register, with no combinational path from mem_rq, which avoids a loop because the execute stage gates mem_rq with ~stop.
- IDLE:
  - mar_wr loads MAR <= mar_in.
  - On mem_rq, capture cmd, width, tag and wr_data, then go to LO with bus_req=1, bus_addr=effective address, bus_we=cmd, bus_wdata=wr_data[7:0].
  - Effective address = mar_in if mar_wr is asserted in the same cycle (bypass), otherwise MAR.
- mar_wr in any non-IDLE state is ignored.
- mem_rq in any non-IDLE state is ignored; no queueing.
- LO: hold all bus outputs until bus_ack=1 is sampled on a rising edge with bus_req=1. On that edge:
  - read: rd_data[7:0] <= bus_rdata; for a byte read, rd_data[15:8] <= 0.
  - width=0 goes to DONE with bus_req=0 and bus_we=0.
  - width=1 goes to HI with bus_addr = incremented address (per PAGE_WRAP) and bus_wdata = wr_data[15:8]. bus_req stays 1; a back-to-back ack is allowed.
- HI: on ack, read captures rd_data[15:8] <= bus_rdata; go to DONE with bus_req=0 and bus_we=0.
- DONE: lasts one cycle.
  - rd_valid=1 for reads only (0 for writes); rd_tag holds the captured tag.
  - Then IDLE.
  - rd_data holds its value until the next read completes.
- bus_ack while bus_req=0 is ignored.
- Minimum latency, byte access: mem_rq at cycle 0, LO in cycle 1 with ack in cycle 1, DONE in cycle 2, IDLE in cycle 3; stop is high in cycles 1-2.
- Minimum latency, word access: one extra cycle (HI).
- Ack wait states extend LO/HI with no limit.

Decomposition:
- Shared include mem_defs.vh holds:
  - state encodings IDLE=2'd0, LO=2'd1, HI=2'd2, DONE=2'd3;
  - MEM_CMD_RD=0, MEM_CMD_WR=1;
  - MEM_W_BYTE=0, MEM_W_WORD=1.
- One sub-module, mem_addr_inc: combinational next-byte address with the PAGE_WRAP parameter, reused by other address paths.

Test Plan:
- Byte read: mar_wr with mar_in=0x1234 at cycle 0; mem_rq read/byte at cycle 2; bus_rdata=0xAB with ack on first cycle -> bus_addr=0x1234, rd_data=0x00AB, rd_valid pulses exactly once, stop high exactly 2 cycles.
- Word write with wait states: MAR=0x20FF, wr_data=0xBEEF, PAGE_WRAP=0; ack delayed 3 cycles per byte -> bus_addr 0x20FF carries wdata 0xEF, then 0x2100 carries 0xBE; bus_we=1 throughout; no rd_valid; stop high until the DONE cycle ends.
- Wrap boundaries, word read at MAR=0x12FF: PAGE_WRAP=1 gives a second address of 0x1200. PAGE_WRAP=0 with MAR=0xFFFF gives a second address of 0x0000. With bytes 0x34 then 0x12, rd_data=0x1234.
- Same-cycle bypass and tag: mar_wr with mar_in=0x4000, mem_rq and mem_tag=1 in the same IDLE cycle, MAR previously 0x1000 -> bus_addr=0x4000, rd_tag=1.
- Busy rejection: mar_wr=1, mar_in=0x5555 and mem_rq during LO -> MAR is unchanged after DONE, no second access starts, and stray bus_ack during IDLE changes nothing.
- Reset mid-operation: deassert a_rst during HI of a word read -> bus_req, stop and rd_valid go to 0 immediately (asynchronously); after release, a fresh byte read completes normally.
